// File: rtl/systolic_mm_ctrl.sv
// Tile sequencer for a weight-stationary N x N systolic array: weight preload,
// skewed activation streaming, then pipeline drain with result writes.
module systolic_mm_ctrl #(
  parameter int N   = 4,
  parameter int K   = 16,
  parameter int LAT = 8,
  parameter int TW  = $clog2(K + LAT + 1),
  localparam int NW = $clog2(N),
  localparam int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stall_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pe_en_o,
  output logic          w_rd_en_o,
  output logic [NW-1:0] w_rd_addr_o,
  output logic          a_rd_en_o,
  output logic [KW-1:0] a_rd_addr_o,
  output logic [N-1:0]  row_en_o,
  output logic          out_wr_en_o,
  output logic [KW-1:0] out_wr_addr_o,
  output logic [2:0]    dbg_state_o
);

  // Handshake: there is no ready path back; stall_i is a one-cycle freeze and
  // every enable is a single-cycle strobe valid only in the cycle it is high.
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  localparam logic [TW-1:0] T_K     = TW'(K);
  localparam logic [TW-1:0] T_SLAST = TW'(K + N - 2);
  localparam logic [TW-1:0] T_LAT   = TW'(LAT);
  localparam logic [TW-1:0] T_WLAST = TW'(LAT + K - 1);
  localparam logic [NW-1:0] W_LAST  = NW'(N - 1);

  state_t        state_q, state_d;
  logic [NW-1:0] w_q, w_d;
  logic [TW-1:0] t_q, t_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD_W;
          w_d     = '0;
          t_d     = '0;
        end
      end
      LOAD_W: begin
        if (!stall_i) begin
          if (w_q == W_LAST) begin
            state_d = STREAM;
            t_d     = '0;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (!stall_i) begin
          t_d = t_q + 1'b1;
          if (t_q == T_SLAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!stall_i) begin
          if (t_q == T_WLAST) state_d = DONE;
          else t_d = t_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        w_d     = '0;
        t_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_tile, in_flow;
  assign in_tile = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
  assign in_flow = (state_q == STREAM) || (state_q == DRAIN);

  always_comb begin
    busy_o        = (state_q != IDLE);
    done_o        = (state_q == DONE);
    pe_en_o       = in_tile && !stall_i;
    w_rd_en_o     = (state_q == LOAD_W) && !stall_i;
    w_rd_addr_o   = (state_q == LOAD_W) ? w_q : '0;
    a_rd_en_o     = (state_q == STREAM) && (t_q < T_K) && !stall_i;
    a_rd_addr_o   = '0;
    row_en_o      = '0;
    out_wr_en_o   = in_flow && (t_q >= T_LAT) && (t_q <= T_WLAST) && !stall_i;
    out_wr_addr_o = '0;
    dbg_state_o   = state_q;
    if (in_flow) begin
      // Past the last vector the read address parks on K-1.
      a_rd_addr_o = (t_q < T_K) ? t_q[KW-1:0] : KW'(K - 1);
      if (t_q >= T_LAT) out_wr_addr_o = KW'(t_q - T_LAT);
    end
    if ((state_q == STREAM) && !stall_i) begin
      for (int r = 0; r < N; r++) begin
        row_en_o[r] = (TW'(r) <= t_q) && (t_q < TW'(r + K));
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: a nominal (4,16,8) instance and a minimal (2,1,2)
// instance, checked each cycle against a tile-progress model plus directed literals.
module tb_systolic_mm_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pe;
    logic       wen;
    logic [3:0] waddr;
    logic       aen;
    logic [3:0] aaddr;
    logic [3:0] row;
    logic       oen;
    logic [3:0] oaddr;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start_a [2];
  logic stall_a [2];
  out_t obs [2];

  // ---------------- DUTs ----------------
  logic       b0, d0, pe0, we0, ae0, oe0;
  logic [1:0] wa0;
  logic [3:0] aa0, oa0, re0;
  logic [2:0] st0;
  systolic_mm_ctrl #(.N(4), .K(16), .LAT(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start_a[0]), .stall_i(stall_a[0]),
    .busy_o(b0), .done_o(d0), .pe_en_o(pe0), .w_rd_en_o(we0), .w_rd_addr_o(wa0),
    .a_rd_en_o(ae0), .a_rd_addr_o(aa0), .row_en_o(re0), .out_wr_en_o(oe0),
    .out_wr_addr_o(oa0), .dbg_state_o(st0));

  logic       b1, d1, pe1, we1, ae1, oe1;
  logic [0:0] wa1, aa1, oa1;
  logic [1:0] re1;
  logic [2:0] st1;
  systolic_mm_ctrl #(.N(2), .K(1), .LAT(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_a[1]), .stall_i(stall_a[1]),
    .busy_o(b1), .done_o(d1), .pe_en_o(pe1), .w_rd_en_o(we1), .w_rd_addr_o(wa1),
    .a_rd_en_o(ae1), .a_rd_addr_o(aa1), .row_en_o(re1), .out_wr_en_o(oe1),
    .out_wr_addr_o(oa1), .dbg_state_o(st1));

  assign obs[0] = {b0, d0, pe0, we0, 4'(wa0), ae0, 4'(aa0), 4'(re0), oe0, 4'(oa0)};
  assign obs[1] = {b1, d1, pe1, we1, 4'(wa1), ae1, 4'(aa1), 4'(re1), oe1, 4'(oa1)};

  // ---------------- behavioural model ----------------
  // A tile is a count p of productive steps since start: N weight steps,
  // then LAT+K stream/drain steps at t=p-N, then the done step.
  bit m_busy [2];
  int m_p    [2];

  function automatic int pn(int d); return (d == 0) ? 4  : 2; endfunction
  function automatic int pk(int d); return (d == 0) ? 16 : 1; endfunction
  function automatic int pl(int d); return (d == 0) ? 8  : 2; endfunction

  function automatic out_t model_out(int n, int k, int lat, bit busy, int p, bit stall);
    out_t o;
    int   t;
    o = '0;
    if (!busy) return o;
    o.busy = 1'b1;
    if (p < n) begin
      o.pe    = !stall;
      o.wen   = !stall;
      o.waddr = 4'(p);
    end else if (p < n + lat + k) begin
      t       = p - n;
      o.pe    = !stall;
      o.aaddr = (t < k) ? 4'(t) : 4'(k - 1);
      o.aen   = (t < k) && !stall;
      if (t <= k + n - 2 && !stall)
        for (int r = 0; r < n; r++) o.row[r] = (r <= t) && (t < r + k);
      o.oen   = (t >= lat) && (t <= lat + k - 1) && !stall;
      o.oaddr = (t >= lat) ? 4'(t - lat) : 4'd0;
    end else begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_p[d]    <= 0;
      end else if (!m_busy[d]) begin
        if (start_a[d]) begin
          m_busy[d] <= 1'b1;
          m_p[d]    <= 0;
        end
      end else if (m_p[d] == pn(d) + pl(d) + pk(d)) begin
        m_busy[d] <= 1'b0;
      end else if (!stall_a[d]) begin
        m_p[d] <= m_p[d] + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cur_d = 0;
  logic [3:0] exp_q [$];
  logic [3:0] got_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        out_t e;
        e = model_out(pn(d), pk(d), pl(d), m_busy[d], m_p[d], stall_a[d]);
        total++;
        if (obs[d] !== e) begin
          bad++;
          $display("FAIL model_cmp dut=%0d cyc=%0d got=%h exp=%h", d, cyc, obs[d], e);
        end
      end
      if (obs[cur_d].oen) got_q.push_back(obs[cur_d].oaddr);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input int k);
    exp_q.delete();
    for (int i = 0; i < k; i++) exp_q.push_back(4'(i));
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({nm, "_addr"}, int'(got_q[i]), int'(exp_q[i]));
  endtask

  // ---------------- driver ----------------
  out_t rec [0:79];
  int   done_q [$];

  task automatic run(input int d, input int stall_at, input int stall_len,
                     input int rst_at, input bit hold_start, input int ncyc);
    cur_d = d;
    got_q.delete();
    done_q.delete();
    for (int rel = 0; rel < ncyc; rel++) begin
      start_a[d] = hold_start || (rel == 0);
      stall_a[d] = (rel >= stall_at) && (rel < stall_at + stall_len);
      rst        = (rel == rst_at);
      @(negedge clk);
      rec[rel] = obs[d];
      if (obs[d].done) done_q.push_back(rel);
      @(posedge clk);
      #1;
    end
    start_a[d] = 1'b0;
    stall_a[d] = 1'b0;
    rst        = 1'b0;
  endtask

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  initial begin
    int n;
    start_a[0] = 0; start_a[1] = 0; stall_a[0] = 0; stall_a[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_dut0", int'(obs[0]), 0);
    chk("reset_dut1", int'(obs[1]), 0);
    chk("reset_state", int'(st0), 0);
    @(posedge clk); #1;

    // 1: nominal tile
    run(0, 99, 0, 99, 1'b0, 34);
    n = 0;
    for (int c = 1; c <= 4; c++) if (rec[c].wen && rec[c].waddr == 4'(c - 1)) n++;
    chk("t1_wload", n, 4);
    n = 0;
    for (int c = 5; c <= 20; c++) if (rec[c].aen && rec[c].aaddr == 4'(c - 5)) n++;
    chk("t1_aread", n, 16);
    chk("t1_aen_off21", int'(rec[21].aen), 0);
    chk("t1_row5", int'(rec[5].row), 4'b0001);
    chk("t1_row8", int'(rec[8].row), 4'b1111);
    chk("t1_row23", int'(rec[23].row), 4'b1000);
    chk("t1_row24", int'(rec[24].row), 4'b0000);
    chk("t1_oen12", int'(rec[12].oen), 0);
    chk("t1_oen13", int'(rec[13].oen), 1);
    chk("t1_oen28", int'(rec[28].oen), 1);
    chk("t1_done_cyc", first_done(), 29);
    chk("t1_done_cnt", done_q.size(), 1);
    chk("t1_busy30", int'(rec[30].busy), 0);
    chk_seq("t1_wr", 16);

    // 2: stall in STREAM at t=5
    run(0, 10, 3, 99, 1'b0, 36);
    for (int c = 10; c <= 12; c++) begin
      chk("t2_stall_aen", int'(rec[c].aen), 0);
      chk("t2_stall_pe", int'(rec[c].pe), 0);
      chk("t2_stall_addr", int'(rec[c].aaddr), 5);
    end
    chk("t2_resume_aen", int'(rec[13].aen), 1);
    chk("t2_resume_addr", int'(rec[13].aaddr), 5);
    chk("t2_done_cyc", first_done(), 32);
    chk_seq("t2_wr", 16);

    // 3: start held high, back-to-back tiles
    run(0, 99, 0, 99, 1'b1, 62);
    chk("t3_done_cnt", done_q.size(), 2);
    chk("t3_done0", first_done(), 29);
    chk("t3_done1", (done_q.size() > 1) ? done_q[1] : -1, 59);
    chk("t3_idle30", int'(rec[30].busy), 0);
    chk("t3_load31", int'(rec[31].wen), 1);
    run(0, 99, 0, 99, 1'b0, 1);
    start_a[0] = 1'b0;
    repeat (35) @(posedge clk);
    #1;

    // 4: reset mid-STREAM
    run(0, 99, 0, 15, 1'b0, 40);
    chk("t4_outputs16", int'(rec[16]), 0);
    chk("t4_no_done", done_q.size(), 0);
    run(0, 99, 0, 99, 1'b0, 34);
    chk("t4_clean_done", first_done(), 29);
    chk_seq("t4_clean_wr", 16);

    // 5: minimal configuration
    run(1, 99, 0, 99, 1'b0, 10);
    chk("t5_row3", int'(rec[3].row), 2'b01);
    chk("t5_row4", int'(rec[4].row), 2'b10);
    chk("t5_oen5", int'(rec[5].oen), 1);
    chk("t5_done_cyc", first_done(), 6);
    chk_seq("t5_wr", 1);

    // 6: stall on the final write
    run(0, 28, 1, 99, 1'b0, 34);
    chk("t6_suppressed", int'(rec[28].oen), 0);
    chk("t6_held_addr", int'(rec[28].oaddr), 15);
    chk("t6_reissue", int'(rec[29].oen), 1);
    chk("t6_reissue_addr", int'(rec[29].oaddr), 15);
    chk("t6_done_cyc", first_done(), 30);
    chk_seq("t6_wr", 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
